// File: rtl/addertree_sched.sv
// Sequencer for the convolution adder tree: owns the per-channel bias table, steps
// channel/window counters and tracks valid/tag/last through the stalled pipeline.
module addertree_sched #(
  parameter int CH_AW      = 6,
  parameter int BIAS_W     = 16,
  parameter int WIN_W      = 16,
  parameter int PIPE_DEPTH = 3
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic [CH_AW:0]    cfg_num_ch,
  input  logic [WIN_W-1:0]  cfg_num_win,
  input  logic              bias_we,
  input  logic [CH_AW-1:0]  bias_waddr,
  input  logic [BIAS_W-1:0] bias_wdata,
  input  logic              in_valid,
  output logic              in_ready,
  output logic [BIAS_W-1:0] bias,
  output logic              pipe_en,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [CH_AW-1:0]  out_ch,
  output logic              out_last,
  output logic              busy,
  output logic              done
);

  localparam int                DEPTH   = 2 ** CH_AW;
  localparam logic [CH_AW:0]    CH_ONE  = 1;
  localparam logic [WIN_W-1:0]  WIN_ONE = 1;

  typedef enum logic [1:0] {
    S_IDLE,
    S_RUN,
    S_DRAIN,
    S_DONE
  } state_t;

  state_t             state;
  logic [CH_AW:0]     num_ch;
  logic [WIN_W-1:0]   num_win;
  logic [CH_AW-1:0]   ch_cnt;
  logic [WIN_W-1:0]   win_cnt;
  logic [BIAS_W-1:0]  bias_mem [DEPTH];

  logic [PIPE_DEPTH-1:0] vld;
  logic [PIPE_DEPTH-1:0] last_sr;
  logic [CH_AW-1:0]      tag_sr [PIPE_DEPTH];

  logic accept;
  logic ch_wrap;
  logic final_beat;
  logic out_fire;

  // The whole pipe moves in lockstep; a stall freezes every stage, bubbles included.
  assign pipe_en    = ~vld[PIPE_DEPTH-1] | out_ready;
  assign in_ready   = (state == S_RUN) & pipe_en;
  assign accept     = in_valid & in_ready;
  assign ch_wrap    = ({1'b0, ch_cnt} == (num_ch - CH_ONE));
  assign final_beat = ch_wrap & (win_cnt == (num_win - WIN_ONE));

  assign bias      = bias_mem[ch_cnt];
  assign out_valid = vld[PIPE_DEPTH-1];
  assign out_ch    = tag_sr[PIPE_DEPTH-1];
  assign out_last  = last_sr[PIPE_DEPTH-1];
  assign out_fire  = out_valid & out_ready & out_last;

  assign busy = (state == S_RUN) | (state == S_DRAIN);
  assign done = (state == S_DONE);

  // NOTE: the bias table sits in flops rather than a RAM so it can be cleared by reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < DEPTH; i++) bias_mem[i] <= '0;
    end else if (bias_we && state == S_IDLE) begin
      bias_mem[bias_waddr] <= bias_wdata;
    end
  end

  // NOTE: all state here uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk) begin
    if (reset) begin
      state   <= S_IDLE;
      num_ch  <= '0;
      num_win <= '0;
      ch_cnt  <= '0;
      win_cnt <= '0;
    end else begin
      case (state)
        S_IDLE: begin
          if (start) begin
            num_ch  <= cfg_num_ch;
            num_win <= cfg_num_win;
            ch_cnt  <= '0;
            win_cnt <= '0;
            state   <= (cfg_num_ch != '0 && cfg_num_win != '0) ? S_RUN : S_DONE;
          end
        end
        S_RUN: begin
          if (accept) begin
            if (ch_wrap) begin
              ch_cnt  <= '0;
              win_cnt <= win_cnt + WIN_ONE;
            end else begin
              ch_cnt <= ch_cnt + CH_AW'(1);
            end
            if (final_beat) state <= S_DRAIN;
          end
        end
        S_DRAIN: begin
          if (out_fire) state <= S_DONE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      vld     <= '0;
      last_sr <= '0;
      for (int k = 0; k < PIPE_DEPTH; k++) tag_sr[k] <= '0;
    end else if (pipe_en) begin
      vld[0]     <= accept;
      last_sr[0] <= accept & final_beat;
      tag_sr[0]  <= ch_cnt;
      for (int k = 1; k < PIPE_DEPTH; k++) begin
        vld[k]     <= vld[k-1];
        last_sr[k] <= last_sr[k-1];
        tag_sr[k]  <= tag_sr[k-1];
      end
    end
  end

endmodule

// File: tb/tb_addertree_sched.sv
// Directed bench for addertree_sched: bias sequencing, latency, backpressure,
// empty layers, bubbles and mid-layer reset, each compared against hand-derived values.
module tb_addertree_sched;

  logic        clk = 1'b0;
  logic        reset;
  logic        start;
  logic [6:0]  cfg_num_ch;
  logic [15:0] cfg_num_win;
  logic        bias_we;
  logic [5:0]  bias_waddr;
  logic [15:0] bias_wdata;
  logic        in_valid;
  logic        in_ready;
  logic [15:0] bias;
  logic        pipe_en;
  logic        out_valid;
  logic        out_ready;
  logic [5:0]  out_ch;
  logic        out_last;
  logic        busy;
  logic        done;

  int n_tests = 0;
  int n_fail  = 0;

  addertree_sched dut (
    .clk(clk), .reset(reset), .start(start),
    .cfg_num_ch(cfg_num_ch), .cfg_num_win(cfg_num_win),
    .bias_we(bias_we), .bias_waddr(bias_waddr), .bias_wdata(bias_wdata),
    .in_valid(in_valid), .in_ready(in_ready), .bias(bias), .pipe_en(pipe_en),
    .out_valid(out_valid), .out_ready(out_ready), .out_ch(out_ch),
    .out_last(out_last), .busy(busy), .done(done)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic start_layer(input logic [6:0] nch, input logic [15:0] nwin);
    cfg_num_ch  = nch;
    cfg_num_win = nwin;
    start       = 1'b1;
    tick();
    start       = 1'b0;
  endtask

  int  exp_idx;
  int  acc;
  bit  done_seen;

  initial begin
    reset = 1'b1; start = 1'b0; cfg_num_ch = '0; cfg_num_win = '0;
    bias_we = 1'b0; bias_waddr = '0; bias_wdata = '0;
    in_valid = 1'b0; out_ready = 1'b0;
    tick(); tick();
    check("rst_out_valid", out_valid, 0);
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_pipe_en", pipe_en, 1);
    check("rst_in_ready", in_ready, 0);
    reset = 1'b0;
    tick();

    // T1: table 1..3 written first, entry 0 written on the start edge itself
    for (int i = 1; i < 4; i++) begin
      bias_we = 1'b1; bias_waddr = 6'(i); bias_wdata = 16'(10 * (i + 1));
      tick();
    end
    bias_waddr = 6'd0; bias_wdata = 16'd10;
    out_ready = 1'b1;
    start_layer(7'd4, 16'd1);
    bias_we = 1'b0;
    for (int c = 0; c < 9; c++) begin
      in_valid = 1'b1;
      #1;
      if (c <= 3) check("t1_bias", bias, 32'(10 * (c + 1)));
      check("t1_in_ready", in_ready, (c <= 3) ? 1 : 0);
      check("t1_out_valid", out_valid, (c >= 3 && c <= 6) ? 1 : 0);
      if (c >= 3 && c <= 6) begin
        check("t1_out_ch", out_ch, 32'(c - 3));
        check("t1_out_last", out_last, (c == 6) ? 1 : 0);
      end
      check("t1_done", done, (c == 7) ? 1 : 0);
      check("t1_busy", busy, (c <= 6) ? 1 : 0);
      tick();
    end
    in_valid = 1'b0;

    // T2: 2 ch x 3 win; a start and a bias write during RUN must both be ignored
    start_layer(7'd2, 16'd3);
    for (int c = 0; c < 11; c++) begin
      in_valid = 1'b1;
      start = (c == 0);
      bias_we = (c == 0); bias_waddr = 6'd1; bias_wdata = 16'd99;
      cfg_num_ch = 7'd1; cfg_num_win = 16'd1;
      #1;
      if (c <= 5) check("t2_bias", bias, (c % 2 == 0) ? 10 : 20);
      check("t2_in_ready", in_ready, (c <= 5) ? 1 : 0);
      check("t2_out_valid", out_valid, (c >= 3 && c <= 8) ? 1 : 0);
      if (c >= 3 && c <= 8) begin
        check("t2_out_ch", out_ch, 32'((c - 3) % 2));
        check("t2_out_last", out_last, (c == 8) ? 1 : 0);
      end
      check("t2_busy", busy, (c <= 8) ? 1 : 0);
      check("t2_done", done, (c == 9) ? 1 : 0);
      tick();
    end
    start = 1'b0; bias_we = 1'b0; in_valid = 1'b0;

    // T3: 4 ch x 2 win with out_ready low for 5 cycles mid-stream
    start_layer(7'd4, 16'd2);
    exp_idx = 0; acc = 0; done_seen = 0;
    for (int c = 0; c < 40 && !done_seen; c++) begin
      out_ready = !(c >= 4 && c <= 8);
      in_valid  = 1'b1;
      #1;
      if (c >= 4 && c <= 8) begin
        check("t3_stall_pipe_en", pipe_en, 0);
        check("t3_stall_in_ready", in_ready, 0);
        check("t3_stall_out_valid", out_valid, 1);
        check("t3_stall_out_ch", out_ch, 1);
      end
      if (in_valid && in_ready) acc++;
      if (out_valid && out_ready) begin
        check("t3_out_ch", out_ch, 32'(exp_idx % 4));
        check("t3_out_last", out_last, (exp_idx == 7) ? 1 : 0);
        exp_idx++;
      end
      if (done) done_seen = 1;
      tick();
    end
    in_valid = 1'b0; out_ready = 1'b1;
    check("t3_done_seen", 32'(done_seen), 1);
    check("t3_accepts", 32'(acc), 8);
    check("t3_outputs", 32'(exp_idx), 8);

    // T4: zero channels completes immediately without ever accepting a beat
    in_valid = 1'b1;
    cfg_num_ch = 7'd0; cfg_num_win = 16'd5; start = 1'b1;
    #1;
    check("t4_in_ready_idle", in_ready, 0);
    tick();
    start = 1'b0;
    check("t4_done", done, 1);
    check("t4_in_ready", in_ready, 0);
    check("t4_busy", busy, 0);
    tick();
    check("t4_done_clear", done, 0);
    check("t4_in_ready_after", in_ready, 0);
    in_valid = 1'b0;

    // T5: in_valid alternating gives bubbles at the output shifted by 3
    start_layer(7'd4, 16'd1);
    for (int c = 0; c < 12; c++) begin
      in_valid = (c % 2 == 0) && (c < 7);
      #1;
      check("t5_out_valid", out_valid, (c >= 3 && c <= 9 && (c - 3) % 2 == 0) ? 1 : 0);
      if (c >= 3 && c <= 9 && (c - 3) % 2 == 0) begin
        check("t5_out_ch", out_ch, 32'((c - 3) / 2));
        check("t5_out_last", out_last, (c == 9) ? 1 : 0);
      end
      check("t5_done", done, (c == 10) ? 1 : 0);
      tick();
    end
    in_valid = 1'b0;

    // T6: reset with two beats in flight aborts the layer and clears the table
    start_layer(7'd4, 16'd4);
    in_valid = 1'b1;
    tick(); tick();
    in_valid = 1'b0;
    check("t6_busy_before", busy, 1);
    check("t6_out_valid_before", out_valid, 0);
    reset = 1'b1;
    tick();
    check("t6_out_valid", out_valid, 0);
    check("t6_busy", busy, 0);
    check("t6_done", done, 0);
    check("t6_pipe_en", pipe_en, 1);
    check("t6_bias_cleared", bias, 0);
    reset = 1'b0;
    for (int c = 0; c < 4; c++) begin
      tick();
      check("t6_post_out_valid", out_valid, 0);
      check("t6_post_done", done, 0);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
